// File: rtl/muldiv_unit_if.sv
// Operand/result bus for the iterative multiply/divide unit.
// The master issues requests; the unit (slave) returns busy/done and the HI/LO result.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    // Handshake: start is sampled only while the unit is idle (busy low) and is
    // ignored otherwise. busy stays high from the accepting edge until the result
    // edge. done is a single-cycle pulse marking hi/lo (and div_by_zero) as freshly
    // written. A new start may be issued in the done cycle itself.
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       state_dbg;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, div_by_zero, hi, lo, state_dbg
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, div_by_zero, hi, lo, state_dbg
    );
endinterface

// File: rtl/muldiv_unit.sv
// MIPS-style mult/multu/div/divu unit: one shift-add or restoring-subtract step per clock.
// Optional MULDIV_EARLY_OUT_EN: multiplies stop iterating once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    muldiv_unit_if.slave       bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_sa_in;
    logic               w_sb_in;
    logic [WIDTH-1:0]   w_a_mag_in;
    logic [WIDTH-1:0]   w_b_mag_in;
    logic               w_is_div;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_a_orig;
    logic               w_dbz;

    // Signed ops iterate on magnitudes; signs are reapplied in FIX.
    assign w_sa_in    = bus.op[0] & bus.operand_a[WIDTH-1];
    assign w_sb_in    = bus.op[0] & bus.operand_b[WIDTH-1];
    assign w_a_mag_in = w_sa_in ? -bus.operand_a : bus.operand_a;
    assign w_b_mag_in = w_sb_in ? -bus.operand_b : bus.operand_b;
    assign w_is_div   = r_op[1];

    // Multiply: accumulate into the top half, shift the whole product right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: top half is the partial remainder, bottom half shifts dividend out / quotient in.
    assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
    assign w_div_next  = w_div_trial[WIDTH]
                       ? {r_acc[2*WIDTH-2:0], 1'b0}
                       : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

`ifdef MULDIV_EARLY_OUT_EN
    assign w_last     = (r_cnt == LAST) || (!w_is_div && (r_b[WIDTH-1:1] == '0));
    // After r_cnt+1 steps the product still sits (LAST - r_cnt) bits too high.
    assign w_prod_mag = r_acc >> (LAST - r_cnt);
`else
    assign w_last     = (r_cnt == LAST);
    assign w_prod_mag = r_acc;
`endif

    assign w_prod   = (r_sign_a ^ r_sign_b) ? -w_prod_mag : w_prod_mag;
    assign w_quo    = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_a_orig = r_sign_a ? -r_a : r_a;
    assign w_dbz    = w_is_div && (r_b == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_CALC;
            S_CALC:  if (w_last)    w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_sign_a <= w_sa_in;
                        r_sign_b <= w_sb_in;
                        r_a      <= w_a_mag_in;
                        r_b      <= w_b_mag_in;
                        r_acc    <= bus.op[1] ? {{WIDTH{1'b0}}, w_a_mag_in} : '0;
                        r_cnt    <= '0;
                        r_dbz    <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (w_is_div) begin
                        r_acc <= w_div_next;
                    end else begin
                        r_acc <= w_mul_next;
                        r_b   <= r_b >> 1;
                    end
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_cnt <= '0;
                    r_dbz <= w_dbz;
                    if (!w_is_div) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (w_dbz) begin
                        r_hi <= w_a_orig;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (r_state == S_CALC) || (r_state == S_FIX);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.state_dbg   = r_state;
endmodule
